// File: rtl/sr_cmd_pkg.sv
// Shared types and configuration for the sr_cmd_gen command front-end.
// Define SR_CMD_SYNC_EN for a two-flop input synchronizer; otherwise a single sampling flop is used.
package sr_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      GAP
   } state_t;

   typedef enum logic {
      SET,
      CLR
   } cmd_t;

`ifdef SR_CMD_SYNC_EN
   localparam int unsigned SYNC_STAGES = 2;
`else
   localparam int unsigned SYNC_STAGES = 1;
`endif

   // Width of a counter spanning 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2((n < 2) ? 2 : n);
   endfunction

endpackage

// File: rtl/sr_debounce.sv
// One request channel: input sampling/synchronizer followed by a level debouncer.
// Synchronizer depth follows SR_CMD_SYNC_EN through sr_cmd_pkg::SYNC_STAGES.
module sr_debounce #(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic stable
);
   import sr_cmd_pkg::*;

   localparam int unsigned    DW      = cnt_width(DB_CYCLES);
   localparam logic [DW-1:0]  DB_LAST = DW'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [DW-1:0]          cnt;
   logic                   sampled;

   assign sampled = sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync   <= '0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         sync[0] <= din;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync[i] <= sync[i-1];
         end
         // A new level is accepted only after DB_CYCLES consecutive disagreeing samples.
         if (sampled == stable) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            stable <= sampled;
            cnt    <= '0;
         end else begin
            cnt <= cnt + DW'(1);
         end
      end
   end

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns raw set/clear request lines into clean, mutually exclusive fixed-width S/R pulses.
// Input synchronizer depth is selected by the SR_CMD_SYNC_EN macro (see sr_cmd_pkg).
module sr_cmd_gen #(
   parameter int unsigned DB_CYCLES = 4,
   parameter int unsigned PULSE_LEN = 1,
   parameter int unsigned GAP_LEN   = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_in,
   input  logic clr_in,
   output logic S,
   output logic R,
   output logic conflict,
   output logic busy
);
   import sr_cmd_pkg::*;

   localparam int unsigned   PW         = cnt_width(PULSE_LEN);
   localparam int unsigned   GW         = cnt_width(GAP_LEN);
   localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

   logic stable_set, stable_clr;
   logic stable_set_d, stable_clr_d;
   logic rise_set, rise_clr;
   logic pend_set, pend_clr;
   logic take_set, take_clr;

   state_t        state, state_next;
   cmd_t          cmd, cmd_next;
   logic [PW-1:0] pulse_cnt, pulse_cnt_next;
   logic [GW-1:0] gap_cnt, gap_cnt_next;
   logic          s_next, r_next, conflict_next, busy_next;

   sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (set_in),
      .stable (stable_set)
   );

   sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (clr_in),
      .stable (stable_clr)
   );

   assign rise_set = stable_set & ~stable_set_d;
   assign rise_clr = stable_clr & ~stable_clr_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stable_set_d <= 1'b0;
         stable_clr_d <= 1'b0;
         pend_set     <= 1'b0;
         pend_clr     <= 1'b0;
      end else begin
         stable_set_d <= stable_set;
         stable_clr_d <= stable_clr;
         // A rise arriving in the same cycle the flag is consumed stays pending.
         pend_set     <= (pend_set & ~take_set) | rise_set;
         pend_clr     <= (pend_clr & ~take_clr) | rise_clr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cmd       <= SET;
         pulse_cnt <= '0;
         gap_cnt   <= '0;
         S         <= 1'b0;
         R         <= 1'b0;
         conflict  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         cmd       <= cmd_next;
         pulse_cnt <= pulse_cnt_next;
         gap_cnt   <= gap_cnt_next;
         S         <= s_next;
         R         <= r_next;
         conflict  <= conflict_next;
         busy      <= busy_next;
      end
   end

   always_comb begin
      state_next     = state;
      cmd_next       = cmd;
      pulse_cnt_next = pulse_cnt;
      gap_cnt_next   = gap_cnt;
      s_next         = 1'b0;
      r_next         = 1'b0;
      conflict_next  = 1'b0;
      take_set       = 1'b0;
      take_clr       = 1'b0;

      case (state)
         IDLE: begin
            if (pend_set && pend_clr) begin
               conflict_next = 1'b1;
               take_set      = 1'b1;
               take_clr      = 1'b1;
            end else if (pend_set) begin
               cmd_next       = SET;
               take_set       = 1'b1;
               state_next     = PULSE;
               pulse_cnt_next = '0;
               s_next         = 1'b1;
            end else if (pend_clr) begin
               cmd_next       = CLR;
               take_clr       = 1'b1;
               state_next     = PULSE;
               pulse_cnt_next = '0;
               r_next         = 1'b1;
            end
         end
         PULSE: begin
            // Outputs are registered, so the pulse was already raised on the IDLE->PULSE edge.
            if (pulse_cnt == PULSE_LAST) begin
               pulse_cnt_next = '0;
               gap_cnt_next   = '0;
               state_next     = (GAP_LEN == 0) ? IDLE : GAP;
            end else begin
               pulse_cnt_next = pulse_cnt + PW'(1);
               s_next         = (cmd == SET);
               r_next         = (cmd == CLR);
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               gap_cnt_next = '0;
               state_next   = IDLE;
            end else begin
               gap_cnt_next = gap_cnt + GW'(1);
            end
         end
         default: state_next = IDLE;
      endcase

      busy_next = (state_next != IDLE);
   end

endmodule
